// File: rtl/image_scaler_pkg.sv
// image_scaler_pkg: shared constants and scale tables for the pyramid address generator (rev 1.0).
`default_nettype none

package image_scaler_pkg;

  localparam int SRC_W     = 640;
  localparam int SRC_H     = 480;
  localparam int MAX_ROUND = 17;
  localparam int ADDR_W    = 19;
  localparam int ACC_W     = 18;
  localparam int CNT_W     = 10;
  localparam int STEP_W    = 13;
  localparam int ROUND_W   = 5;

  // step_r = round(256 * 1.2^r) in Q8.8
  localparam logic [STEP_W-1:0] STEP [0:MAX_ROUND] = '{
    13'd256,  13'd307,  13'd369,  13'd442,  13'd531,  13'd637,
    13'd764,  13'd917,  13'd1101, 13'd1321, 13'd1585, 13'd1902,
    13'd2283, 13'd2739, 13'd3287, 13'd3944, 13'd4733, 13'd5680
  };

  // W_r = floor(SRC_W*256 / step_r), H_r = floor(SRC_H*256 / step_r)
  localparam logic [CNT_W-1:0] W [0:MAX_ROUND] = '{
    10'd640, 10'd533, 10'd444, 10'd370, 10'd308, 10'd257,
    10'd214, 10'd178, 10'd148, 10'd124, 10'd103, 10'd86,
    10'd71,  10'd59,  10'd49,  10'd41,  10'd34,  10'd28
  };

  localparam logic [CNT_W-1:0] H [0:MAX_ROUND] = '{
    10'd480, 10'd400, 10'd333, 10'd278, 10'd231, 10'd192,
    10'd160, 10'd134, 10'd111, 10'd93,  10'd77,  10'd64,
    10'd53,  10'd44,  10'd37,  10'd31,  10'd25,  10'd21
  };

  function automatic logic [ROUND_W-1:0] clamp_round(input logic [ROUND_W-1:0] r);
    return (r > ROUND_W'(MAX_ROUND)) ? ROUND_W'(MAX_ROUND) : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/image_scaler_if.sv
// image_scaler_if: control inputs and address outputs of the pyramid address generator (rev 1.0).
`default_nettype none

interface image_scaler_if;
  import image_scaler_pkg::*;

  logic               en;
  logic [ROUND_W-1:0] round_scale;
  logic [ADDR_W-1:0]  addr_request;
  logic [ADDR_W-1:0]  addr_scale;

  modport master (
    output en,
    output round_scale,
    input  addr_request,
    input  addr_scale
  );

  modport slave (
    input  en,
    input  round_scale,
    output addr_request,
    output addr_scale
  );

endinterface

`default_nettype wire

// File: rtl/image_scaler_src_addr.sv
// image_scaler_src_addr: source-frame address y*640 + x built from shifts and adds (rev 1.0).
`default_nettype none

module image_scaler_src_addr
  import image_scaler_pkg::*;
(
  input  logic [CNT_W-1:0]  x_i,
  input  logic [CNT_W-1:0]  y_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] x_ext;

  assign y_ext  = {{(ADDR_W-CNT_W){1'b0}}, y_i};
  assign x_ext  = {{(ADDR_W-CNT_W){1'b0}}, x_i};
  // 640 = 512 + 128
  assign addr_o = (y_ext << 9) + (y_ext << 7) + x_ext;

endmodule

`default_nettype wire

// File: rtl/image_scaler.sv
// image_scaler: nearest-neighbour pyramid address generator, one scaled pixel per enabled cycle (rev 1.0).
// Optional registered frame_done output when IMGSCL_DONE_EN is defined.
`default_nettype none

module image_scaler
  import image_scaler_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  image_scaler_if.slave bus
`ifdef IMGSCL_DONE_EN
  ,
  output logic          frame_done
`endif
);

  logic [CNT_W-1:0]   xd_q, xd_d, yd_q, yd_d;
  logic [ACC_W-1:0]   xa_q, xa_d, ya_q, ya_d;
  logic [ADDR_W-1:0]  sa_q, sa_d;
  logic [ADDR_W-1:0]  req_q, req_d;
  logic [ROUND_W-1:0] rq_q, rq_d;

  logic [ACC_W-1:0]   step;
  logic [CNT_W-1:0]   x_end;
  logic [CNT_W-1:0]   y_end;
  logic               last_x;
  logic               last_y;

  always_comb begin
    step   = {{(ACC_W-STEP_W){1'b0}}, STEP[rq_q]};
    x_end  = W[rq_q] - 10'd1;
    y_end  = H[rq_q] - 10'd1;
    last_x = (xd_q == x_end);
    last_y = (yd_q == y_end);
  end

  always_comb begin
    xd_d = xd_q;
    yd_d = yd_q;
    xa_d = xa_q;
    ya_d = ya_q;
    sa_d = sa_q;
    rq_d = rq_q;
    if (bus.en) begin
      if (last_x && last_y) begin
        xd_d = '0;
        yd_d = '0;
        xa_d = '0;
        ya_d = '0;
        sa_d = '0;
        rq_d = clamp_round(bus.round_scale);
      end else if (last_x) begin
        xd_d = '0;
        xa_d = '0;
        yd_d = yd_q + 10'd1;
        ya_d = ya_q + step;
        sa_d = sa_q + 19'd1;
      end else begin
        xd_d = xd_q + 10'd1;
        xa_d = xa_q + step;
        sa_d = sa_q + 19'd1;
      end
    end else if ((xd_q == '0) && (yd_q == '0)) begin
      // idle at the top of a frame: the next frame may pick up a new round
      rq_d = clamp_round(bus.round_scale);
    end
  end

  // address is computed from next-state accumulators so it lines up with sa_q
  image_scaler_src_addr u_src_addr (
    .x_i    (xa_d[ACC_W-1:8]),
    .y_i    (ya_d[ACC_W-1:8]),
    .addr_o (req_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      xd_q  <= '0;
      yd_q  <= '0;
      xa_q  <= '0;
      ya_q  <= '0;
      sa_q  <= '0;
      req_q <= '0;
      rq_q  <= clamp_round(bus.round_scale);
    end else begin
      xd_q  <= xd_d;
      yd_q  <= yd_d;
      xa_q  <= xa_d;
      ya_q  <= ya_d;
      sa_q  <= sa_d;
      req_q <= req_d;
      rq_q  <= rq_d;
    end
  end

  assign bus.addr_scale   = sa_q;
  assign bus.addr_request = req_q;

`ifdef IMGSCL_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (bus.en) begin
      done_d = (xd_d == x_end) && (yd_d == y_end);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign frame_done = done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_scaler.sv
// tb_image_scaler: scoreboard bench for image_scaler with an independent reference model.
`default_nettype none

module tb_image_scaler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_scaler_if bus ();

`ifdef IMGSCL_DONE_EN
  logic frame_done;
  image_scaler dut (.clk(clk), .rst(rst), .bus(bus), .frame_done(frame_done));
`else
  image_scaler dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    int    req;
    int    sa;
    bit    fd;
    string nm;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  // reference model state
  int m_x = 0, m_y = 0, m_xa = 0, m_ya = 0, m_sa = 0, m_rq = 0;
  bit m_fd = 0;

  // hand-computed table for the rounds exercised here
  function automatic int t_step(input int r);
    case (r)
      0: return 256;  1: return 307;  16: return 4733;  17: return 5680;
      default: return 256;
    endcase
  endfunction
  function automatic int t_w(input int r);
    case (r)
      0: return 640;  1: return 533;  16: return 34;  17: return 28;
      default: return 640;
    endcase
  endfunction
  function automatic int t_h(input int r);
    case (r)
      0: return 480;  1: return 400;  16: return 25;  17: return 21;
      default: return 480;
    endcase
  endfunction
  function automatic int clampr(input int r);
    return (r > 17) ? 17 : r;
  endfunction

  task automatic drive(input bit e, input int rs, input bit r, input string nm);
    exp_t ex;
    bit lx, ly;
    @(negedge clk);
    bus.en          = e;
    bus.round_scale = 5'(rs);
    rst             = r;
    if (r) begin
      m_x = 0; m_y = 0; m_xa = 0; m_ya = 0; m_sa = 0; m_fd = 0;
      m_rq = clampr(rs);
    end else if (e) begin
      lx = (m_x == t_w(m_rq) - 1);
      ly = (m_y == t_h(m_rq) - 1);
      if (lx && ly) begin
        m_x = 0; m_y = 0; m_xa = 0; m_ya = 0; m_sa = 0;
        m_rq = clampr(rs);
      end else if (lx) begin
        m_x = 0; m_xa = 0; m_y++; m_ya += t_step(m_rq); m_sa++;
      end else begin
        m_x++; m_xa += t_step(m_rq); m_sa++;
      end
      m_fd = (m_x == t_w(m_rq) - 1) && (m_y == t_h(m_rq) - 1);
    end else if (m_x == 0 && m_y == 0) begin
      m_rq = clampr(rs);
    end
    ex.req = (m_ya / 256) * 640 + (m_xa / 256);
    ex.sa  = m_sa;
    ex.fd  = m_fd;
    ex.nm  = nm;
    exp_q.push_back(ex);
  endtask

  task automatic run(input bit e, input int rs, input int n, input string nm);
    for (int i = 0; i < n; i++) drive(e, rs, 1'b0, nm);
  endtask

  // monitor: pop one expectation per clock once stimulus has been issued
  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      total_cnt++;
      if (int'(bus.addr_request) == ex.req) pass_cnt++;
      else $display("FAIL %s addr_request: got %0d expected %0d (addr_scale exp %0d)",
                    ex.nm, bus.addr_request, ex.req, ex.sa);
      total_cnt++;
      if (int'(bus.addr_scale) == ex.sa) pass_cnt++;
      else $display("FAIL %s addr_scale: got %0d expected %0d", ex.nm, bus.addr_scale, ex.sa);
`ifdef IMGSCL_DONE_EN
      total_cnt++;
      if (frame_done == ex.fd) pass_cnt++;
      else $display("FAIL %s frame_done: got %0b expected %0b (addr_scale exp %0d)",
                    ex.nm, frame_done, ex.fd, ex.sa);
`endif
    end
  end

  initial begin
    bus.en          = 1'b0;
    bus.round_scale = 5'd0;

    // reset state
    drive(1'b0, 0, 1'b1, "reset");
    drive(1'b0, 0, 1'b1, "reset");
    drive(1'b0, 0, 1'b0, "reset_idle");

    // round 0: identity addressing across a couple of row boundaries
    run(1'b1, 0, 1400, "r0");

    // round 1: 0,1,2,3,4,5,7,... and 640 at addr_scale 533
    drive(1'b0, 1, 1'b1, "r1_rst");
    run(1'b1, 1, 1300, "r1");

    // round 17: two full frames plus wrap
    drive(1'b0, 17, 1'b1, "r17_rst");
    run(1'b1, 17, 588 * 2 + 5, "r17");

    // round 25 clamps to 17
    drive(1'b0, 25, 1'b1, "clamp_rst");
    run(1'b1, 25, 600, "clamp25");

    // en low mid-row holds everything
    drive(1'b0, 17, 1'b1, "hold_rst");
    run(1'b1, 17, 10, "hold_pre");
    run(1'b0, 17, 5, "hold");
    run(1'b1, 17, 20, "hold_post");

    // round change mid-frame only takes effect after the wrap
    run(1'b1, 16, 588 + 60, "midchg");

    // reset mid-frame clears both outputs next cycle
    run(1'b1, 16, 10, "rst_pre");
    drive(1'b1, 16, 1'b1, "rst_mid");

    // idle at pixel (0,0) reloads the round
    drive(1'b0, 17, 1'b1, "idle_rst");
    run(1'b0, 1, 2, "idle_rl");
    run(1'b1, 1, 600, "idle_run");

    drive(1'b0, 1, 1'b0, "tail");
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
